selection_sort_core: RTL and testbench

Datapath engine behind the sort_controller AXI4-Lite register file. It holds DEPTH words in a local register array and sorts them in place into ascending order by selection sort, one compare per cycle. The controller loads the words through a simple write port, pulses start, polls busy/done, then reads the sorted words back through a registered read port.

---
 rtl/sort_pkg.sv | 18 +
 rtl/selection_sort_lt.sv | 16 +
 rtl/selection_sort_core.sv | 137 +++++++++++++
 tb/tb_selection_sort_core.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the selection sort datapath.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } sort_state_t;

  localparam int unsigned SORT_DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned SORT_DEPTH_MAX          = 16;

  // Cycles from the accepted start edge until done is visible.
  function automatic int unsigned sort_cycles(input int unsigned depth);
    return (depth * (depth - 1)) / 2 + depth - 1;
  endfunction

endpackage

// File: rtl/selection_sort_lt.sv
// Combinational a < b comparator; SORT_SIGNED_EN selects two's-complement compare.
module selection_sort_lt #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  lt_c
);

`ifdef SORT_SIGNED_EN
  assign lt_c = $signed(a_i) < $signed(b_i);
`else
  assign lt_c = a_i < b_i;
`endif

endmodule

// File: rtl/selection_sort_core.sv
// In-place ascending selection sort over a local register array.
// Optional macro SORT_SIGNED_EN switches the element compare to signed.
module selection_sort_core
  import sort_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = SORT_DATA_WIDTH_DEFAULT,
  parameter  int unsigned DEPTH      = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  sort_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] i_q, i_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic [ADDR_WIDTH-1:0] min_q, min_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  lt_c;
  logic                  wr_in_range_c;
  logic                  rd_in_range_c;

  assign wr_in_range_c = 32'(wr_addr) < DEPTH;
  assign rd_in_range_c = 32'(rd_addr) < DEPTH;

  // Candidate element versus the current running minimum.
  selection_sort_lt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lt (
    .a_i  (mem_q[j_q]),
    .b_i  (mem_q[min_q]),
    .lt_c (lt_c)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (j_q == LAST_J) state_d = SWAP;
      SWAP:    state_d = (i_q == LAST_I) ? IDLE : SCAN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    mem_d     = mem_q;
    i_d       = i_q;
    j_d       = j_q;
    min_d     = min_q;
    busy_d    = busy_q;
    done_d    = done_q;
    rd_data_d = rd_in_range_c ? mem_q[rd_addr] : '0;
    case (state_q)
      IDLE: begin
        // Write lands before a same-cycle start so the sort sees it.
        if (wr_en && wr_in_range_c) begin
          mem_d[wr_addr] = wr_data;
          done_d         = 1'b0;
        end
        if (start) begin
          i_d    = '0;
          min_d  = '0;
          j_d    = ONE;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      SCAN: begin
        if (lt_c) min_d = j_q;
        if (j_q != LAST_J) j_d = j_q + ONE;
      end
      SWAP: begin
        mem_d[i_q]   = mem_q[min_q];
        mem_d[min_q] = mem_q[i_q];
        if (i_q == LAST_I) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          i_d   = i_q + ONE;
          min_d = i_q + ONE;
          j_d   = i_q + ONE + ONE;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
      i_q       <= '0;
      j_q       <= '0;
      min_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      i_q       <= i_d;
      j_q       <= j_d;
      min_q     <= min_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_selection_sort_core.sv
// Directed self-checking bench for selection_sort_core (DEPTH=8, 32-bit).
module tb_selection_sort_core;
  import sort_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 8;
  localparam int unsigned AW = 3;

  logic          ACLK;
  logic          ARESETN;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          start;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] vec   [DP];
  logic [DW-1:0] exp_v [DP];

  selection_sort_core #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .start   (start),
    .busy    (busy),
    .done    (done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge ACLK);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge ACLK);
    rd_addr = a;
    @(posedge ACLK); #1;
    d = rd_data;
  endtask

  task automatic load_vec();
    for (int k = 0; k < int'(DP); k++) write_word(AW'(k), vec[k]);
  endtask

  task automatic check_vec(input string tag);
    logic [DW-1:0] d;
    for (int k = 0; k < int'(DP); k++) begin
      read_word(AW'(k), d);
      check_eq($sformatf("%s[%0d]", tag, k), d, exp_v[k]);
    end
  endtask

  // Pulse start, then count cycles with busy high; optional injections at cycle inject / rst_at.
  task automatic run_sort(input int inject, input int rst_at, output int n);
    @(negedge ACLK);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      if (n == inject) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 32'h0000_DEAD; start = 1'b1;
      end
      if (n == rst_at) ARESETN = 1'b0;
      n++;
      @(posedge ACLK); #1;
      wr_en = 1'b0; start = 1'b0;
    end
  endtask

  task automatic sort_and_check(input string tag, input int inject);
    int n;
    run_sort(inject, -1, n);
    check_eq({tag, "_cycles"}, DW'(n), DW'(sort_cycles(DP)));
    check_eq({tag, "_done"}, DW'(done), 32'd1);
    check_eq({tag, "_busy"}, DW'(busy), 32'd0);
    check_vec(tag);
  endtask

  initial begin
    int n;
    logic [DW-1:0] d;
    ARESETN = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; start = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_busy", DW'(busy), 32'd0);
    check_eq("rst_done", DW'(done), 32'd0);
    check_eq("rst_rdata", rd_data, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Mixed values
    vec   = '{5, 3, 8, 1, 9, 2, 7, 4};
    exp_v = '{1, 2, 3, 4, 5, 7, 8, 9};
    load_vec();
    sort_and_check("mixed", -1);

    // Presorted
    vec   = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_v = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_vec();
    sort_and_check("presorted", -1);

    // Reversed
    vec   = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_vec();
    sort_and_check("reversed", -1);

    // Duplicates, then done stickiness
    vec   = '{4, 4, 1, 1, 9, 0, 9, 0};
    exp_v = '{0, 0, 1, 1, 4, 4, 9, 9};
    load_vec();
    sort_and_check("dups", -1);
    check_eq("done_sticky", DW'(done), 32'd1);
    write_word(3'd2, 32'd77);
    check_eq("done_clr_wr", DW'(done), 32'd0);

    // Write and start during busy are ignored
    vec   = '{5, 3, 8, 1, 9, 2, 7, 4};
    exp_v = '{1, 2, 3, 4, 5, 7, 8, 9};
    load_vec();
    sort_and_check("busy_ign", 5);

    // Reset at cycle 10 of a sort
    vec = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_vec();
    run_sort(-1, 10, n);
    check_eq("abort_cycles", DW'(n), 32'd11);
    check_eq("abort_busy", DW'(busy), 32'd0);
    check_eq("abort_done", DW'(done), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_vec("abort_clr");
    vec   = '{5, 3, 8, 1, 9, 2, 7, 4};
    exp_v = '{1, 2, 3, 4, 5, 7, 8, 9};
    load_vec();
    sort_and_check("post_abort", -1);

    // Signedness corner
    vec = '{32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0};
`ifdef SORT_SIGNED_EN
    exp_v = '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 1};
`else
    exp_v = '{0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF};
`endif
    load_vec();
    sort_and_check("sign", -1);
    read_word(3'd7, d);
    check_eq("rd_after", d, exp_v[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
